ctlb_param: RTL and testbench
=============================

CTLB_PARAM -- requirements
Module: ctlb_param

Interface
REQ-001 Parameter WAYS, default 4, associativity; legal values 2, 4, 8.
REQ-002 Parameter SET_BITS, default 6, log2 of set count; SETS = 2^SET_BITS.
REQ-003 Parameter VPN_W, default 52, virtual page number width.
REQ-004 Parameter DATA_W, default 32, translation payload width.
REQ-005 Parameter GLOBAL_BIT, default 0, index of the global flag inside the payload.
REQ-006 Ports are clk and rst; one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 lookup_en  in  1  lookup request.
REQ-010 stall  in  1  freezes pipeline registers and outputs.
REQ-011 lookup_vpn  in  VPN_W  page number to translate.
REQ-012 lookup_nat  in  1  native-mode lookup; index vpn[SET_BITS+3:4], else vpn[SET_BITS-1:0].
REQ-013 sproc  in  16  current address-space id.
REQ-014 hit  out  1  registered lookup hit.
REQ-015 hit_data  out  DATA_W  payload of hitting way; zero on miss.
REQ-016 hit_way  out  log2(WAYS)  index of hitting way.
REQ-017 fill_en  in  1  write translation for the last looked-up vpn.
REQ-018 fill_data  in  DATA_W  payload to write.
REQ-019 fill_nat  in  1  mode of filled entry.
REQ-020 flush_req  in  1  one-cycle pulse requesting a flush sweep.
REQ-021 flush_global  in  1  sampled with flush_req; 1 also clears global entries.
REQ-022 busy  out  1  init or flush sweep in progress.
REQ-023 flush_ack  out  1  one-cycle pulse when flush sweep completes.

Function
REQ-024 Entry = {valid, validN, sproc tag, vpn tag, payload, age[log2(WAYS)-1:0]}.
REQ-025 Hit per way: (valid&~nat | validN&nat) and vpn tag equal and (stored sproc equal sproc or payload[GLOBAL_BIT]=1).
REQ-026 Lookup latency 1 cycle: lookup_en&~stall&~busy in cycle N -> hit/hit_data/hit_way valid in N+1, held while stall=1.
REQ-027 Lookup while busy=1 is ignored; hit=0 next cycle.
REQ-028 LRU by per-way age: on hit, hit way age->0, ways with age below old hit age increment; others unchanged.
REQ-029 Fill targets the set of the last accepted lookup; victim = way with age WAYS-1; victim age->0, all others increment.
REQ-030 Fill writes valid=~fill_nat, validN=fill_nat, tags from registered lookup vpn and sproc.
REQ-031 Fill in the same cycle as a lookup of the same set: lookup returns pre-fill contents; fill wins the write port.
REQ-032 Fill while busy=1 is dropped.
REQ-033 Multiple-way hit (software error): hit=1, hit_way = lowest index, hit_data = that way's payload.
REQ-034 FSM states INIT, IDLE, FLUSH; INIT->IDLE after SETS cycles; IDLE->FLUSH on flush_req; FLUSH->IDLE after SETS cycles with flush_ack=1 on the final cycle.
REQ-035 Sweep counter width SET_BITS, counts 0..SETS-1, one set per cycle, not halted by stall.
REQ-036 INIT sweep writes valid=validN=0, tags=0, payload=0, age=way index.
REQ-037 FLUSH sweep clears valid/validN of every entry, except entries with payload[GLOBAL_BIT]=1 when flush_global=0; ages unchanged.
REQ-038 flush_req during INIT or FLUSH is latched (one deep, with flush_global) and serviced immediately after the current sweep.
REQ-039 busy=1 in INIT and FLUSH, 0 in IDLE.

Reset
REQ-040 rst=0 at a clock edge: state->INIT, counter->0, hit=0, hit_data=0, hit_way=0, flush_ack=0, busy=1, pending flush cleared.
REQ-041 rst=0 mid-sweep restarts INIT from set 0; array contents need no reset beyond the INIT sweep.

Verification
REQ-042 Release rst, WAYS=4, SET_BITS=6 -> busy=1 for 64 cycles, then 0; first lookup misses.
REQ-043 Lookup vpn 0x123 miss, fill payload 0xABCD, relookup -> hit=1, hit_data=0xABCD one cycle after request.
REQ-044 Fill 5 distinct vpns mapping to set 3 -> first-filled vpn misses, other four hit.
REQ-045 Global entry with sproc=1, lookup with sproc=2 -> hit; flush_global=0 -> still hits; flush_global=1 -> miss after flush_ack.
REQ-046 flush_req during INIT -> busy stays 1 for 128 cycles total, single flush_ack at the end.
REQ-047 Native fill of vpn 0x40, non-native lookup of same vpn -> miss; native lookup -> hit.

Source files
------------

// File: rtl/ctlb_param.sv
// Set-associative translation lookaside buffer with per-way age LRU, init and flush sweeps.
// Latency: lookup result registered one cycle after an accepted request; fill written in one cycle.
// Backpressure: stall freezes the lookup pipeline and outputs; lookups and fills are ignored while busy.
//
// Ports:
//   clk, rst                       sole clock (rising edge), synchronous active-low reset
//   lookup_en/vpn/nat, sproc       lookup request, page number, native mode, address-space id
//   hit, hit_data, hit_way         registered lookup result (payload zero on miss)
//   fill_en/data/nat               write a translation for the last accepted lookup
//   flush_req, flush_global        start a flush sweep; flush_global also drops global entries
//   busy, flush_ack                sweep in progress; one-cycle pulse on the last flush cycle
module ctlb_param #(
    parameter int WAYS       = 4,
    parameter int SET_BITS   = 6,
    parameter int VPN_W      = 52,
    parameter int DATA_W     = 32,
    parameter int GLOBAL_BIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lookup_en,
    input  logic                    stall,
    input  logic [VPN_W-1:0]        lookup_vpn,
    input  logic                    lookup_nat,
    input  logic [15:0]             sproc,
    output logic                    hit,
    output logic [DATA_W-1:0]       hit_data,
    output logic [$clog2(WAYS)-1:0] hit_way,
    input  logic                    fill_en,
    input  logic [DATA_W-1:0]       fill_data,
    input  logic                    fill_nat,
    input  logic                    flush_req,
    input  logic                    flush_global,
    output logic                    busy,
    output logic                    flush_ack
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << SET_BITS;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
    localparam logic [WAY_W-1:0]    OLDEST   = WAY_W'(WAYS - 1);

    if (!(WAYS == 2 || WAYS == 4 || WAYS == 8)) begin : g_bad_ways
        $error("ctlb_param: WAYS must be 2, 4 or 8");
    end
    if (VPN_W < SET_BITS + 4) begin : g_bad_vpn
        $error("ctlb_param: VPN_W too narrow for native indexing");
    end

    typedef struct packed {
        logic              v;      // valid for non-native lookups
        logic              vn;     // valid for native lookups
        logic [15:0]       sproc;
        logic [VPN_W-1:0]  vpn;    // full vpn kept as tag so both index modes compare safely
        logic [DATA_W-1:0] data;
        logic [WAY_W-1:0]  age;    // 0 = most recent, WAYS-1 = next victim
    } entry_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    entry_t mem_q [SETS][WAYS];

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                pend_glob_q, pend_glob_d;
    logic                glob_q, glob_d;

    logic                hit_q;
    logic [DATA_W-1:0]   hit_data_q;
    logic [WAY_W-1:0]    hit_way_q;

    logic [SET_BITS-1:0] lk_set_q;
    logic [VPN_W-1:0]    lk_vpn_q;
    logic [15:0]         lk_sproc_q;

    logic [SET_BITS-1:0] lk_set;
    logic                lk_acc;
    logic                lk_found;
    logic [WAY_W-1:0]    lk_sel;
    logic [DATA_W-1:0]   lk_data;
    logic [WAY_W-1:0]    lk_age;
    logic                fill_ok;
    logic [WAY_W-1:0]    vict;
    logic                lru_upd;
    logic                sweep_last;

    assign busy       = (state_q != ST_IDLE);
    assign sweep_last = (cnt_q == LAST_SET);
    assign flush_ack  = (state_q == ST_FLUSH) && sweep_last;

    assign lk_set  = lookup_nat ? lookup_vpn[SET_BITS+3:4] : lookup_vpn[SET_BITS-1:0];
    assign lk_acc  = lookup_en && !stall && !busy;
    assign fill_ok = fill_en && !busy;
    // A fill to the set being looked up owns the write; the lookup's age update is dropped.
    assign lru_upd = lk_acc && lk_found && !(fill_ok && (lk_set == lk_set_q));

    // Tag match; the lowest matching way wins if software created duplicates.
    always_comb begin
        lk_found = 1'b0;
        lk_sel   = '0;
        lk_data  = '0;
        lk_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (((mem_q[lk_set][w].v && !lookup_nat) || (mem_q[lk_set][w].vn && lookup_nat)) &&
                (mem_q[lk_set][w].vpn == lookup_vpn) &&
                ((mem_q[lk_set][w].sproc == sproc) || mem_q[lk_set][w].data[GLOBAL_BIT]) &&
                !lk_found) begin
                lk_found = 1'b1;
                lk_sel   = WAY_W'(w);
                lk_data  = mem_q[lk_set][w].data;
                lk_age   = mem_q[lk_set][w].age;
            end
        end
    end

    // Ages within a set form a permutation, so exactly one way holds the oldest age.
    always_comb begin
        vict = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem_q[lk_set_q][w].age == OLDEST) begin
                vict = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_glob_d = pend_glob_q;
        glob_d      = glob_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    glob_d  = flush_global;
                end
            end
            ST_INIT, ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_req) begin
                    pend_d      = 1'b1;
                    pend_glob_d = flush_global;
                end
                if (sweep_last) begin
                    if (pend_q || flush_req) begin
                        state_d = ST_FLUSH;
                        glob_d  = flush_req ? flush_global : pend_glob_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_glob_q <= 1'b0;
            glob_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_glob_q <= pend_glob_d;
            glob_q      <= glob_d;
        end
    end

    // Array has no reset of its own; the INIT sweep establishes every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[cnt_q][w] <= '{v: 1'b0, vn: 1'b0, sproc: '0, vpn: '0,
                                         data: '0, age: WAY_W'(w)};
                end
            end else if (state_q == ST_FLUSH) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (glob_q || !mem_q[cnt_q][w].data[GLOBAL_BIT]) begin
                        mem_q[cnt_q][w].v  <= 1'b0;
                        mem_q[cnt_q][w].vn <= 1'b0;
                    end
                end
            end else begin
                if (fill_ok) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == vict) begin
                            mem_q[lk_set_q][w] <= '{v: !fill_nat, vn: fill_nat, sproc: lk_sproc_q,
                                                    vpn: lk_vpn_q, data: fill_data, age: '0};
                        end else begin
                            mem_q[lk_set_q][w].age <= mem_q[lk_set_q][w].age + 1'b1;
                        end
                    end
                end
                if (lru_upd) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == lk_sel) begin
                            mem_q[lk_set][w].age <= '0;
                        end else if (mem_q[lk_set][w].age < lk_age) begin
                            mem_q[lk_set][w].age <= mem_q[lk_set][w].age + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q      <= 1'b0;
            hit_data_q <= '0;
            hit_way_q  <= '0;
        end else if (!stall) begin
            hit_q      <= lk_acc && lk_found;
            hit_data_q <= lk_acc ? lk_data : '0;
            hit_way_q  <= lk_acc ? lk_sel : '0;
        end
    end

    // Context of the last accepted lookup, consumed by a following fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lk_set_q   <= '0;
            lk_vpn_q   <= '0;
            lk_sproc_q <= '0;
        end else if (lk_acc) begin
            lk_set_q   <= lk_set;
            lk_vpn_q   <= lookup_vpn;
            lk_sproc_q <= sproc;
        end
    end

    assign hit      = hit_q;
    assign hit_data = hit_data_q;
    assign hit_way  = hit_way_q;

endmodule

// File: tb/tb_ctlb_param.sv
module tb_ctlb_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_en, stall, lookup_nat;
    logic [51:0] lookup_vpn;
    logic [15:0] sproc;
    logic        hit;
    logic [31:0] hit_data;
    logic [1:0]  hit_way;
    logic        fill_en, fill_nat;
    logic [31:0] fill_data;
    logic        flush_req, flush_global;
    logic        busy, flush_ack;

    always #5 clk = ~clk;

    ctlb_param dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .stall(stall), .lookup_vpn(lookup_vpn),
        .lookup_nat(lookup_nat), .sproc(sproc),
        .hit(hit), .hit_data(hit_data), .hit_way(hit_way),
        .fill_en(fill_en), .fill_data(fill_data), .fill_nat(fill_nat),
        .flush_req(flush_req), .flush_global(flush_global),
        .busy(busy), .flush_ack(flush_ack)
    );

    typedef struct packed {
        logic        h;
        logic [31:0] d;
        logic [1:0]  w;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: a lookup presented un-stalled at an edge is checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (lookup_en && !stall && rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lk_hit", 64'(hit), 64'(e.h));
                    chk("lk_data", 64'(hit_data), 64'(e.d));
                    chk("lk_way", 64'(hit_way), 64'(e.w));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic lookup(input logic [51:0] vpn, input logic nat, input logic [15:0] sp,
                          input logic eh, input logic [31:0] ed, input logic [1:0] ew);
        exp_t e;
        e.h = eh; e.d = ed; e.w = ew;
        lookup_en  = 1'b1;
        lookup_vpn = vpn;
        lookup_nat = nat;
        sproc      = sp;
        exp_q.push_back(e);
        @(posedge clk); #1;
        lookup_en = 1'b0;
    endtask

    task automatic fill(input logic [31:0] d, input logic nat);
        fill_en   = 1'b1;
        fill_data = d;
        fill_nat  = nat;
        @(posedge clk); #1;
        fill_en = 1'b0;
    endtask

    task automatic flush(input logic g);
        flush_req    = 1'b1;
        flush_global = g;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    // Counts samples with busy=1 (from now) and flush_ack pulses; optional flush pulse at sample 10.
    task automatic count_busy(input logic req_flush, output int n, output int acks);
        n = 0; acks = 0;
        while (busy && n < 400) begin
            if (flush_ack) acks++;
            flush_req    = req_flush && (n == 10);
            flush_global = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        flush_req = 1'b0;
        if (n >= 400) chk("busy_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n, acks;
        logic [1:0] k_way [5];
        k_way = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

        rst = 1'b0; lookup_en = 0; stall = 0; lookup_nat = 0; lookup_vpn = '0; sproc = '0;
        fill_en = 0; fill_nat = 0; fill_data = '0; flush_req = 0; flush_global = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_ack", 64'(flush_ack), 64'd0);

        rst = 1'b1;
        count_busy(1'b0, n, acks);
        chk("init_cycles", 64'(n), 64'd64);
        chk("init_acks", 64'(acks), 64'd0);

        // miss, fill, hit
        lookup(52'h123, 0, 16'd1, 0, 32'h0, 2'd0);
        fill(32'hABCD, 0);
        lookup(52'h123, 0, 16'd1, 1, 32'hABCD, 2'd3);

        // five vpns into set 3: the first one is evicted by LRU
        for (int k = 1; k <= 5; k++) begin
            lookup(52'(3 + 64 * k), 0, 16'd1, 0, 32'h0, 2'd0);
            fill(32'(32'h1000 + 2 * k), 0);
        end
        lookup(52'(3 + 64), 0, 16'd1, 0, 32'h0, 2'd0);
        for (int k = 2; k <= 5; k++) begin
            lookup(52'(3 + 64 * k), 0, 16'd1, 1, 32'(32'h1000 + 2 * k), k_way[k-1]);
        end

        // native entries only hit native lookups
        lookup(52'h40, 1, 16'd1, 0, 32'h0, 2'd0);
        fill(32'h2222_0000, 1);
        lookup(52'h40, 0, 16'd1, 0, 32'h0, 2'd0);
        lookup(52'h40, 1, 16'd1, 1, 32'h2222_0000, 2'd3);
        // 0x3FF indexes set 63 in both modes, so only the valid/validN split separates them
        lookup(52'h3FF, 1, 16'd1, 0, 32'h0, 2'd0);
        fill(32'h30, 1);
        lookup(52'h3FF, 0, 16'd1, 0, 32'h0, 2'd0);
        lookup(52'h3FF, 1, 16'd1, 1, 32'h30, 2'd3);

        // stall holds the previous result
        stall = 1'b1; lookup_en = 1'b1; lookup_vpn = 52'h999; lookup_nat = 1'b0;
        @(posedge clk); #1;
        chk("stall_hit", 64'(hit), 64'd1);
        chk("stall_data", 64'(hit_data), 64'h30);
        lookup_en = 1'b0; stall = 1'b0;

        // global entry and flushes
        lookup(52'h200, 0, 16'd1, 0, 32'h0, 2'd0);
        fill(32'h5555_0001, 0);
        lookup(52'h200, 0, 16'd2, 1, 32'h5555_0001, 2'd3);
        flush(1'b0);
        lookup(52'h123, 0, 16'd1, 0, 32'h0, 2'd0);
        count_busy(1'b0, n, acks);
        chk("flush0_acks", 64'(acks), 64'd1);
        lookup(52'h200, 0, 16'd2, 1, 32'h5555_0001, 2'd3);
        lookup(52'h123, 0, 16'd1, 1, 32'hABCD, 2'd3);
        lookup(52'h83, 0, 16'd1, 0, 32'h0, 2'd0);
        flush(1'b1);
        count_busy(1'b0, n, acks);
        chk("flush1_acks", 64'(acks), 64'd1);
        lookup(52'h200, 0, 16'd2, 0, 32'h0, 2'd0);
        lookup(52'h123, 0, 16'd1, 0, 32'h0, 2'd0);

        // reset clears a held hit even under stall
        lookup(52'h3FF, 1, 16'd1, 0, 32'h0, 2'd0);
        fill(32'h30, 1);
        lookup(52'h3FF, 1, 16'd1, 1, 32'h30, 2'd2);
        stall = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst2_hit", 64'(hit), 64'd0);
        chk("rst2_data", 64'(hit_data), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd1);
        stall = 1'b0; rst = 1'b1;

        // reset mid-sweep restarts INIT; flush requested during INIT follows it
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        count_busy(1'b1, n, acks);
        chk("init_flush_cycles", 64'(n), 64'd128);
        chk("init_flush_acks", 64'(acks), 64'd1);
        lookup(52'h3FF, 1, 16'd1, 0, 32'h0, 2'd0);
        lookup(52'h40, 1, 16'd1, 0, 32'h0, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
